// File: rtl/tx_chksum_input_controller_pkg.sv
// tx_chksum_input_controller_pkg: shared widths, TCP/pseudo-header layouts and payload-length helper
package tx_chksum_input_controller_pkg;
  localparam int IP_ADDR_W = 32;
  localparam int TOT_LEN_W = 16;
  localparam int MAC_INTERFACE_W = 256;
  localparam int MAC_PADBYTES_W = 5;
  localparam int TCP_HDR_W = 160;
  localparam int CHKSUM_PSEUDO_HDR_W = 96;
  localparam logic [7:0] TCP_PROTO = 8'd6;
  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  raw_data_offset;
    logic [11:0] flags;
    logic [15:0] win_size;
    logic [15:0] chksum;
    logic [15:0] urg_ptr;
  } tcp_pkt_hdr;
  typedef struct packed {
    logic [IP_ADDR_W-1:0] src_ip;
    logic [IP_ADDR_W-1:0] dst_ip;
    logic [7:0]           zero;
    logic [7:0]           protocol;
    logic [TOT_LEN_W-1:0] tcp_len;
  } chksum_pseudo_hdr;
  typedef enum logic {HDR, PAYLOAD} state_t;
  // Returns {underflow, payload_len}; an underflowing length collapses to zero.
  function automatic logic [TOT_LEN_W:0] calc_payload_len(input logic [TOT_LEN_W-1:0] tcp_len,
                                                          input logic [3:0] data_offset);
    logic [TOT_LEN_W-1:0] hdr_bytes;
    hdr_bytes = TOT_LEN_W'({data_offset, 2'b00});
    return (tcp_len < hdr_bytes) ? {1'b1, {TOT_LEN_W{1'b0}}} : {1'b0, tcp_len - hdr_bytes};
  endfunction
endpackage

// File: rtl/tx_chksum_input_controller_if.sv
// tx_chksum_input_controller_if: descriptor, payload and request-stream signals of the packer
interface tx_chksum_input_controller_if;
  import tx_chksum_input_controller_pkg::*;
  logic                       src_chksum_tx_hdr_val;
  logic                       chksum_src_tx_hdr_rdy;
  logic [IP_ADDR_W-1:0]       src_chksum_tx_src_ip;
  logic [IP_ADDR_W-1:0]       src_chksum_tx_dst_ip;
  logic [TOT_LEN_W-1:0]       src_chksum_tx_tcp_len;
  tcp_pkt_hdr                 src_chksum_tx_tcp_hdr;
  logic                       src_chksum_tx_data_val;
  logic                       chksum_src_tx_data_rdy;
  logic [MAC_INTERFACE_W-1:0] src_chksum_tx_data;
  logic                       src_chksum_tx_data_last;
  logic [MAC_PADBYTES_W-1:0]  src_chksum_tx_data_padbytes;
  logic [MAC_INTERFACE_W-1:0] req_tdata;
  logic [MAC_INTERFACE_W/8-1:0] req_tkeep;
  logic                       req_tvalid;
  logic                       req_tready;
  logic                       req_tlast;
  modport master (
    output src_chksum_tx_hdr_val, src_chksum_tx_src_ip, src_chksum_tx_dst_ip,
           src_chksum_tx_tcp_len, src_chksum_tx_tcp_hdr, src_chksum_tx_data_val,
           src_chksum_tx_data, src_chksum_tx_data_last, src_chksum_tx_data_padbytes, req_tready,
    input  chksum_src_tx_hdr_rdy, chksum_src_tx_data_rdy, req_tdata, req_tkeep, req_tvalid, req_tlast
  );
  modport slave (
    input  src_chksum_tx_hdr_val, src_chksum_tx_src_ip, src_chksum_tx_dst_ip,
           src_chksum_tx_tcp_len, src_chksum_tx_tcp_hdr, src_chksum_tx_data_val,
           src_chksum_tx_data, src_chksum_tx_data_last, src_chksum_tx_data_padbytes, req_tready,
    output chksum_src_tx_hdr_rdy, chksum_src_tx_data_rdy, req_tdata, req_tkeep, req_tvalid, req_tlast
  );
endinterface

// File: rtl/tx_chksum_input_controller_keep_gen.sv
// tx_chksum_keep_gen: byte enables and data mask for a payload beat; pad bytes sit at the LSB end
module tx_chksum_keep_gen #(
  parameter int KEEP_WIDTH = 32,
  parameter int PAD_W = $clog2(KEEP_WIDTH)
) (
  input  logic [PAD_W-1:0]        padbytes,
  input  logic                    last,
  output logic [KEEP_WIDTH-1:0]   keep,
  output logic [8*KEEP_WIDTH-1:0] mask
);
  assign keep = last ? {KEEP_WIDTH{1'b1}} << padbytes : {KEEP_WIDTH{1'b1}};
  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_mask
    assign mask[8*i+:8] = {8{keep[i]}};
  end
endmodule

// File: rtl/tx_chksum_input_controller.sv
// tx_chksum_input_controller: packs a TCP descriptor and its payload stream into one AXI-stream packet
module tx_chksum_input_controller
  import tx_chksum_input_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tx_chksum_input_controller_if.slave   bus,
  output logic                          len_err
);
  localparam int CW = TOT_LEN_W;
  localparam int PW = MAC_PADBYTES_W;
  state_t state, state_n;
  tcp_pkt_hdr hdr;
  chksum_pseudo_hdr pseudo;
  logic can_load, hdr_fire, data_fire, last, underflow, zero_pay, cnt_bad, pad_bad;
  logic [CW-1:0] plen, exp_beats, exp_beats_n, beat_cnt;
  logic [PW-1:0] exp_pad, exp_pad_n;
  logic [KEEP_WIDTH-1:0] keep;
  logic [DATA_WIDTH-1:0] mask;
  assign hdr  = bus.src_chksum_tx_tcp_hdr;
  assign last = bus.src_chksum_tx_data_last;
  assign {underflow, plen} = calc_payload_len(bus.src_chksum_tx_tcp_len, hdr.raw_data_offset);
  assign zero_pay = plen == '0;
  assign pseudo = '{src_ip: bus.src_chksum_tx_src_ip, dst_ip: bus.src_chksum_tx_dst_ip,
                    zero: 8'h00, protocol: TCP_PROTO, tcp_len: bus.src_chksum_tx_tcp_len};
  assign exp_beats_n = CW'((32'(plen) + KEEP_WIDTH - 1) / KEEP_WIDTH);
  assign exp_pad_n   = PW'((KEEP_WIDTH - 32'(plen) % KEEP_WIDTH) % KEEP_WIDTH);
  // Ready is gated by rst_n so neither side can hand over a beat while the block is held in reset.
  assign can_load = !bus.req_tvalid || bus.req_tready;
  assign bus.chksum_src_tx_hdr_rdy  = rst_n && state == HDR && can_load;
  assign bus.chksum_src_tx_data_rdy = rst_n && state == PAYLOAD && can_load;
  assign hdr_fire  = bus.src_chksum_tx_hdr_val && bus.chksum_src_tx_hdr_rdy;
  assign data_fire = bus.src_chksum_tx_data_val && bus.chksum_src_tx_data_rdy;
  assign cnt_bad = beat_cnt + CW'(1) != exp_beats;
  assign pad_bad = bus.src_chksum_tx_data_padbytes != exp_pad;
  tx_chksum_keep_gen #(.KEEP_WIDTH(KEEP_WIDTH), .PAD_W(PW)) u_keep_gen (
    .padbytes (bus.src_chksum_tx_data_padbytes),
    .last     (last),
    .keep     (keep),
    .mask     (mask)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HDR;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (hdr_fire && !zero_pay) state_n = PAYLOAD;
    if (data_fire && last) state_n = HDR;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_beats <= '0;
      exp_pad   <= '0;
      beat_cnt  <= '0;
    end else if (hdr_fire) begin
      exp_beats <= exp_beats_n;
      exp_pad   <= exp_pad_n;
      beat_cnt  <= '0;
    end else if (data_fire) beat_cnt <= beat_cnt + CW'(1);
  // Length errors are reported only; framing always follows data_last.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) len_err <= 1'b0;
    else if ((hdr_fire && underflow) || (data_fire && last && (cnt_bad || pad_bad))) len_err <= 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.req_tvalid <= 1'b0;
      bus.req_tdata  <= '0;
      bus.req_tkeep  <= '0;
      bus.req_tlast  <= 1'b0;
    end else if (hdr_fire) begin
      bus.req_tvalid <= 1'b1;
      bus.req_tdata  <= {pseudo, hdr};
      bus.req_tkeep  <= '1;
      bus.req_tlast  <= zero_pay;
    end else if (data_fire) begin
      bus.req_tvalid <= 1'b1;
      bus.req_tdata  <= bus.src_chksum_tx_data & mask;
      bus.req_tkeep  <= keep;
      bus.req_tlast  <= last;
    end else if (bus.req_tready) bus.req_tvalid <= 1'b0;
endmodule

// File: tb/tb_tx_chksum_input_controller.sv
// tb_tx_chksum_input_controller: table vectors, corner sequences and random packets against a byte-level model
module tb_tx_chksum_input_controller;
  import tx_chksum_input_controller_pkg::*;
  typedef struct { logic [255:0] d; logic [31:0] k; logic l; } beat_t;
  typedef struct {
    int tcp_len; int doff; int nbeats; int pad; int mode; bit rst_before;
    int exp_out; logic [31:0] exp_keep; logic exp_err;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic len_err;
  tx_chksum_input_controller_if bus();
  tx_chksum_input_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus), .len_err(len_err));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  beat_t exp_q[$];
  int rdy_mode = 0;
  int beats_seen = 0;
  logic [31:0] last_keep_seen = '0;
  bit data_rdy_seen = 0;
  bit model_err = 0;
  vec_t vecs[12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic abort(input string what);
    tests++;
    fails++;
    $display("FAIL %s: timed out", what);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  function automatic beat_t model_hdr(input logic [31:0] s, input logic [31:0] d,
                                      input logic [15:0] len, input tcp_pkt_hdr h);
    beat_t r;
    int p;
    p = int'(len) - 4 * int'(h.raw_data_offset);
    r.d = {s, d, 8'h00, 8'd6, len, h};
    r.k = '1;
    r.l = p <= 0;
    return r;
  endfunction

  // Byte j of a beat is the j-th payload byte, stored MSB-first.
  function automatic beat_t model_pay(input logic [255:0] raw, input bit last, input int pad);
    beat_t r;
    int nv;
    nv = last ? 32 - pad : 32;
    r.d = '0;
    r.k = '0;
    r.l = last;
    for (int j = 0; j < 32; j++)
      if (j < nv) begin
        r.d[255-8*j -: 8] = raw[255-8*j -: 8];
        r.k[31-j] = 1'b1;
      end
    return r;
  endfunction

  function automatic bit err_rule(input int tcp_len, input int doff, input int nbeats, input int pad);
    int p;
    p = tcp_len - 4 * doff;
    if (p < 0) return 1;
    return nbeats > 0 && (nbeats != (p + 31) / 32 || pad != (32 - p % 32) % 32);
  endfunction

  task automatic drive_hdr(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                           input tcp_pkt_hdr h);
    int n = 0;
    bit ok = 0;
    @(negedge clk);
    bus.src_chksum_tx_data_val = 0;
    bus.src_chksum_tx_hdr_val = 1;
    bus.src_chksum_tx_src_ip = s;
    bus.src_chksum_tx_dst_ip = d;
    bus.src_chksum_tx_tcp_len = len;
    bus.src_chksum_tx_tcp_hdr = h;
    while (!ok) begin
      #4 ok = bus.chksum_src_tx_hdr_rdy;
      @(posedge clk);
      if (!ok) begin
        if (++n > 500) abort("hdr_handshake");
        @(negedge clk);
      end
    end
  endtask

  task automatic drive_data(input logic [255:0] raw, input bit last, input int pad);
    int n = 0;
    bit ok = 0;
    @(negedge clk);
    bus.src_chksum_tx_hdr_val = 0;
    bus.src_chksum_tx_data_val = 1;
    bus.src_chksum_tx_data = raw;
    bus.src_chksum_tx_data_last = last;
    bus.src_chksum_tx_data_padbytes = 5'(pad);
    while (!ok) begin
      #4 ok = bus.chksum_src_tx_data_rdy;
      @(posedge clk);
      if (!ok) begin
        if (++n > 500) abort("data_handshake");
        @(negedge clk);
      end
    end
  endtask

  task automatic send_hdr(input int tcp_len, input int doff);
    logic [31:0] s, d;
    tcp_pkt_hdr h;
    s = $urandom();
    d = $urandom();
    h = tcp_pkt_hdr'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    h.raw_data_offset = 4'(doff);
    exp_q.push_back(model_hdr(s, d, 16'(tcp_len), h));
    drive_hdr(s, d, 16'(tcp_len), h);
  endtask

  task automatic send_beat(input bit last, input int pad);
    logic [255:0] raw;
    for (int i = 0; i < 8; i++) raw[32*i +: 32] = $urandom();
    exp_q.push_back(model_pay(raw, last, pad));
    drive_data(raw, last, pad);
  endtask

  task automatic send_pkt(input int tcp_len, input int doff, input int nbeats, input int pad);
    model_err |= err_rule(tcp_len, doff, nbeats, pad);
    send_hdr(tcp_len, doff);
    for (int b = 0; b < nbeats; b++) send_beat(b == nbeats - 1, b == nbeats - 1 ? pad : 0);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.src_chksum_tx_hdr_val = 0;
    bus.src_chksum_tx_data_val = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.req_tvalid) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check(name, 256'(n >= 2000), 256'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.src_chksum_tx_hdr_val = 0;
    bus.src_chksum_tx_data_val = 0;
    rst_n = 0;
    exp_q.delete();
    model_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Output monitor: drives req_tready, scores accepted beats and checks AXI stall behaviour.
  initial begin
    bit stalled = 0;
    beat_t held, e;
    bus.req_tready = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.req_tready = 1;
        1: bus.req_tready = ($urandom() % 3) != 0;
        default: bus.req_tready = ~bus.req_tready;
      endcase
      #4;
      if (rst_n) begin
        data_rdy_seen |= bus.chksum_src_tx_data_rdy;
        if (stalled)
          check("stall_hold", {bus.req_tdata ^ held.d, bus.req_tkeep ^ held.k, bus.req_tlast ^ held.l, !bus.req_tvalid}, '0);
        stalled = bus.req_tvalid && !bus.req_tready;
        if (stalled) begin
          held = '{bus.req_tdata, bus.req_tkeep, bus.req_tlast};
          check("rdy_while_stalled", 256'({bus.chksum_src_tx_hdr_rdy, bus.chksum_src_tx_data_rdy}), 256'(0));
        end
        if (bus.req_tvalid && bus.req_tready) begin
          beats_seen++;
          if (bus.req_tlast) last_keep_seen = bus.req_tkeep;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got d=%h k=%h l=%b expected none", bus.req_tdata, bus.req_tkeep, bus.req_tlast);
          end else begin
            e = exp_q.pop_front();
            tests++;
            if ({bus.req_tdata, bus.req_tkeep, bus.req_tlast} !== {e.d, e.k, e.l}) begin
              fails++;
              $display("FAIL beat: got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                       bus.req_tdata, bus.req_tkeep, bus.req_tlast, e.d, e.k, e.l);
            end
          end
        end
      end else stalled = 0;
    end
  end

  initial begin
    int p, doff, nb;
    vecs[0]  = '{20,  5, 0, 0,  0, 0, 1, 32'hFFFFFFFF, 0};
    vecs[1]  = '{84,  5, 2, 0,  0, 0, 3, 32'hFFFFFFFF, 0};
    vecs[2]  = '{60,  5, 2, 24, 0, 0, 3, 32'hFF000000, 0};
    vecs[3]  = '{108, 5, 3, 8,  2, 0, 4, 32'hFFFFFF00, 0};
    vecs[4]  = '{44,  6, 1, 12, 1, 0, 2, 32'hFFFFF000, 0};
    vecs[5]  = '{20,  5, 0, 0,  0, 0, 1, 32'hFFFFFFFF, 0};
    vecs[6]  = '{24,  5, 1, 28, 1, 0, 2, 32'hF0000000, 0};
    vecs[7]  = '{84,  5, 1, 0,  0, 0, 2, 32'hFFFFFFFF, 1};
    vecs[8]  = '{84,  5, 2, 0,  2, 0, 3, 32'hFFFFFFFF, 1};
    vecs[9]  = '{10,  5, 0, 0,  0, 1, 1, 32'hFFFFFFFF, 1};
    vecs[10] = '{60,  5, 2, 0,  0, 1, 3, 32'hFFFFFFFF, 1};
    vecs[11] = '{52,  5, 1, 0,  1, 1, 2, 32'hFFFFFFFF, 0};
    bus.src_chksum_tx_hdr_val = 0;
    bus.src_chksum_tx_data_val = 0;
    bus.src_chksum_tx_src_ip = '0;
    bus.src_chksum_tx_dst_ip = '0;
    bus.src_chksum_tx_tcp_len = '0;
    bus.src_chksum_tx_tcp_hdr = '0;
    bus.src_chksum_tx_data = '0;
    bus.src_chksum_tx_data_last = 0;
    bus.src_chksum_tx_data_padbytes = '0;
    #3;
    check("rst_tvalid", 256'(bus.req_tvalid), 256'(0));
    check("rst_tdata", bus.req_tdata, '0);
    check("rst_tkeep_tlast", 256'({bus.req_tkeep, bus.req_tlast}), 256'(0));
    check("rst_len_err", 256'(len_err), 256'(0));
    check("rst_rdy", 256'({bus.chksum_src_tx_hdr_rdy, bus.chksum_src_tx_data_rdy}), 256'(0));
    @(negedge clk);
    rst_n = 1;
    foreach (vecs[v]) begin
      rdy_mode = vecs[v].mode;
      if (vecs[v].rst_before) do_reset();
      beats_seen = 0;
      data_rdy_seen = 0;
      send_pkt(vecs[v].tcp_len, vecs[v].doff, vecs[v].nbeats, vecs[v].pad);
      idle();
      wait_drain($sformatf("drain_v%0d", v));
      check($sformatf("beats_v%0d", v), 256'(beats_seen), 256'(vecs[v].exp_out));
      check($sformatf("last_keep_v%0d", v), 256'(last_keep_seen), 256'(vecs[v].exp_keep));
      check($sformatf("len_err_v%0d", v), 256'(len_err), 256'(vecs[v].exp_err));
      if (vecs[v].nbeats == 0) check($sformatf("no_data_rdy_v%0d", v), 256'(data_rdy_seen), 256'(0));
    end
    // Asynchronous reset in the middle of a three-beat packet.
    do_reset();
    rdy_mode = 0;
    send_hdr(116, 5);
    send_beat(0, 0);
    #2;
    check("tvalid_before_rst", 256'(bus.req_tvalid), 256'(1));
    rst_n = 0;
    #1;
    check("async_rst_tvalid", 256'(bus.req_tvalid), 256'(0));
    check("async_rst_tdata", bus.req_tdata, '0);
    check("async_rst_rdy", 256'({bus.chksum_src_tx_hdr_rdy, bus.chksum_src_tx_data_rdy}), 256'(0));
    exp_q.delete();
    model_err = 0;
    bus.src_chksum_tx_data_val = 0;
    @(negedge clk);
    rst_n = 1;
    send_pkt(84, 5, 2, 0);
    idle();
    wait_drain("drain_after_rst");
    check("len_err_after_rst", 256'(len_err), 256'(0));
    // Random well-formed packets, back to back, with varying ready patterns.
    for (int r = 0; r < 40; r++) begin
      rdy_mode = $urandom_range(0, 2);
      doff = $urandom_range(5, 15);
      p = ($urandom() % 4 == 0) ? 0 : $urandom_range(1, 150);
      nb = (p + 31) / 32;
      send_pkt(p + 4 * doff, doff, nb, (32 - p % 32) % 32);
    end
    idle();
    wait_drain("drain_random");
    check("len_err_random", 256'(len_err), 256'(model_err));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
